// File: rtl/vga_axil_pkg.sv
// Shared AXI-Lite types, CSR offsets, control-register layout and decode helpers
// for the VGA CSR block.
package vga_axil_pkg;

   typedef logic [31:0] axil_addr_t;
   typedef logic [31:0] axil_data_t;
   typedef logic [3:0]  axil_strb_t;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } axil_resp_e;

   typedef axil_resp_e axil_resp_t;

   localparam axil_addr_t CSR_CTRL_OFFS    = 32'h0000_0000;
   localparam axil_addr_t CSR_BG_OFFS      = 32'h0000_0004;
   localparam axil_addr_t CSR_STATUS_OFFS  = 32'h0000_0008;
   localparam axil_addr_t CSR_SCRATCH_OFFS = 32'h0000_000C;

   typedef struct packed {
      logic irq_en;
      logic test_pattern;
      logic enable;
   } csr_ctrl_t;

   typedef enum logic [2:0] {
      SEL_CTRL,
      SEL_BG,
      SEL_STATUS,
      SEL_SCRATCH,
      SEL_NONE
   } csr_sel_e;

   // Word-address decode; the byte-lane bits never take part.
   function automatic csr_sel_e csr_decode(input logic [31:2] waddr);
      if (waddr == CSR_CTRL_OFFS[31:2])    return SEL_CTRL;
      if (waddr == CSR_BG_OFFS[31:2])      return SEL_BG;
      if (waddr == CSR_STATUS_OFFS[31:2])  return SEL_STATUS;
      if (waddr == CSR_SCRATCH_OFFS[31:2]) return SEL_SCRATCH;
      return SEL_NONE;
   endfunction

   function automatic axil_data_t strb_to_mask(input axil_strb_t strb);
      axil_data_t m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
      return m;
   endfunction

endpackage

// File: rtl/vga_axil_if.sv
// AXI-Lite bus between the register master and the VGA CSR block.
interface vga_axil_if;
   import vga_axil_pkg::*;

   axil_addr_t awaddr;
   logic       awvalid;
   logic       awready;
   axil_data_t wdata;
   axil_strb_t wstrb;
   logic       wvalid;
   logic       wready;
   axil_resp_t bresp;
   logic       bvalid;
   logic       bready;
   axil_addr_t araddr;
   logic       arvalid;
   logic       arready;
   axil_data_t rdata;
   axil_resp_t rresp;
   logic       rvalid;
   logic       rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/vga_axil_wr_hold.sv
// Single-entry valid/payload holding register; an arriving beat is visible on out_* in the
// same cycle, so a consumer can take it without a bubble. Accepts only while empty.
module vga_axil_wr_hold #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   output logic [W-1:0] out_dat,
   input  logic         take
);

   logic         held_vld;
   logic [W-1:0] held_dat;

   assign in_rdy  = !held_vld;
   assign out_vld = held_vld | in_vld;
   assign out_dat = held_vld ? held_dat : in_dat;

   always_ff @(posedge clk) begin
      if (rst) begin
         held_vld <= 1'b0;
         held_dat <= '0;
      end else if (take) begin
         held_vld <= 1'b0;
      end else if (in_vld && !held_vld) begin
         held_vld <= 1'b1;
         held_dat <= in_dat;
      end
   end

endmodule

// File: rtl/vga_axil_csr.sv
// AXI-Lite CSR slave for the VGA core: write commits with the last of AW/W, B/R one cycle later,
// no new commit while B is pending. VGA_AXIL_CSR_STRB_EN enables per-byte write strobes.
module vga_axil_csr
   import vga_axil_pkg::*;
#(
   parameter logic [11:0] BG_RESET = 12'h000
) (
   input  logic              clk,
   input  logic              rst,
   vga_axil_if.slave         axil,
   input  logic              frame_done_i,
   input  logic [15:0]       frame_cnt_i,
   output logic              enable_o,
   output logic              test_pattern_o,
   output logic [11:0]       bg_color_o,
   output logic              irq_o
);

   localparam int AW_W = $bits(axil_addr_t);
   localparam int W_W  = $bits(axil_data_t) + $bits(axil_strb_t);

   logic           aw_vld;
   axil_addr_t     aw_addr;
   logic           w_vld;
   logic [W_W-1:0] w_bundle;
   axil_data_t     w_data;
   axil_strb_t     w_strb;
   axil_data_t     wr_mask;
   csr_sel_e       wr_sel;
   csr_sel_e       rd_sel;
   axil_data_t     rd_word;
   logic           commit;
   logic           fd_clr;

   csr_ctrl_t      ctrl;
   logic [11:0]    bg;
   logic           frame_done;
   axil_data_t     scratch;
   logic           irq_q;

   vga_axil_wr_hold #(.W(AW_W)) u_aw_hold (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (axil.awvalid),
      .in_rdy  (axil.awready),
      .in_dat  (axil.awaddr),
      .out_vld (aw_vld),
      .out_dat (aw_addr),
      .take    (commit)
   );

   vga_axil_wr_hold #(.W(W_W)) u_w_hold (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (axil.wvalid),
      .in_rdy  (axil.wready),
      .in_dat  ({axil.wdata, axil.wstrb}),
      .out_vld (w_vld),
      .out_dat (w_bundle),
      .take    (commit)
   );

   assign {w_data, w_strb} = w_bundle;

`ifdef VGA_AXIL_CSR_STRB_EN
   assign wr_mask = strb_to_mask(w_strb);
`else
   logic unused_strb;
   assign unused_strb = ^w_strb;
   assign wr_mask     = '1;
`endif

   logic unused_addr_lsb;
   assign unused_addr_lsb = ^{aw_addr[1:0], axil.araddr[1:0]};

   // A pending B response stalls commits; the holds keep filling meanwhile.
   assign commit = aw_vld && w_vld && !axil.bvalid;
   assign wr_sel = csr_decode(aw_addr[31:2]);
   assign fd_clr = commit && (wr_sel == SEL_STATUS) && w_data[0] && wr_mask[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl       <= '0;
         bg         <= BG_RESET;
         scratch    <= '0;
         frame_done <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         if (commit) begin
            case (wr_sel)
               SEL_CTRL:    ctrl    <= csr_ctrl_t'((ctrl & ~wr_mask[2:0]) | (w_data[2:0] & wr_mask[2:0]));
               SEL_BG:      bg      <= (bg & ~wr_mask[11:0]) | (w_data[11:0] & wr_mask[11:0]);
               SEL_SCRATCH: scratch <= (scratch & ~wr_mask) | (w_data & wr_mask);
               default: ;
            endcase
         end
         frame_done <= frame_done_i | (frame_done & !fd_clr);
         irq_q      <= frame_done & ctrl.irq_en;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         axil.bvalid <= 1'b0;
         axil.bresp  <= OKAY;
      end else if (commit) begin
         axil.bvalid <= 1'b1;
         axil.bresp  <= (wr_sel == SEL_NONE) ? SLVERR : OKAY;
      end else if (axil.bready) begin
         axil.bvalid <= 1'b0;
      end
   end

   assign rd_sel = csr_decode(axil.araddr[31:2]);

   always_comb begin
      rd_word = '0;
      case (rd_sel)
         SEL_CTRL:    rd_word = {29'd0, ctrl};
         SEL_BG:      rd_word = {20'd0, bg};
         SEL_STATUS:  rd_word = {frame_cnt_i, 15'd0, frame_done};
         SEL_SCRATCH: rd_word = scratch;
         default:     rd_word = '0;
      endcase
   end

   assign axil.arready = !axil.rvalid;

   // Read data is sampled from the current registers, so a same-cycle write is not visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         axil.rvalid <= 1'b0;
         axil.rdata  <= '0;
         axil.rresp  <= OKAY;
      end else if (axil.arvalid && !axil.rvalid) begin
         axil.rvalid <= 1'b1;
         axil.rdata  <= rd_word;
         axil.rresp  <= (rd_sel == SEL_NONE) ? SLVERR : OKAY;
      end else if (axil.rready) begin
         axil.rvalid <= 1'b0;
      end
   end

   assign enable_o       = ctrl.enable;
   assign test_pattern_o = ctrl.test_pattern;
   assign bg_color_o     = bg;
   assign irq_o          = irq_q;

endmodule

// File: tb/tb_vga_axil_csr.sv
// Bench for vga_axil_csr: directed scenarios plus randomized AXI-Lite traffic, all outputs
// compared every cycle against a register-map model held in the bench.
module tb_vga_axil_csr;
   import vga_axil_pkg::*;

   localparam logic [11:0] TB_BG = 12'h5A5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_done_i = 1'b0;
   logic [15:0] frame_cnt_i = 16'h0;
   logic        enable_o;
   logic        test_pattern_o;
   logic [11:0] bg_color_o;
   logic        irq_o;

   vga_axil_if bus ();

   vga_axil_csr #(.BG_RESET(TB_BG)) dut (
      .clk            (clk),
      .rst            (rst),
      .axil           (bus.slave),
      .frame_done_i   (frame_done_i),
      .frame_cnt_i    (frame_cnt_i),
      .enable_o       (enable_o),
      .test_pattern_o (test_pattern_o),
      .bg_color_o     (bg_color_o),
      .irq_o          (irq_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: no handshake within 40 cycles, expected one", name);
   endtask

   // ---------------- register-map model ----------------
   // m_reg: 0 CTRL, 1 BG_COLOR, 2 STATUS (FRAME_DONE in bit 0), 3 SCRATCH
   logic [31:0] m_reg [4];
   bit          m_on = 1'b0;
   bit          m_aw_h, m_w_h, m_b, m_r, m_irq;
   logic [31:0] m_awaddr, m_wdata, m_rdata;
   logic [3:0]  m_wstrb;
   logic [1:0]  m_bresp, m_rresp;

   function automatic int idx_of(input logic [31:0] a);
      return (a[31:4] == 28'd0) ? int'(a[3:2]) : -1;
   endfunction

   function automatic logic [31:0] rw_mask(input int i);
      case (i)
         0:       return 32'h0000_0007;
         1:       return 32'h0000_0FFF;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input int i);
      case (i)
         0, 1, 3: return m_reg[i];
         2:       return {frame_cnt_i, 15'd0, m_reg[2][0]};
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      bit          aw_ok, w_ok, commit, nxt_irq;
      logic [31:0] a, d, mask;
      logic [3:0]  s;
      int          wi, ri;
      if (rst) begin
         m_on   = 1'b1;
         m_aw_h = 0; m_w_h = 0; m_b = 0; m_r = 0; m_irq = 0;
         m_reg[0] = 32'd0;
         m_reg[1] = {20'd0, TB_BG};
         m_reg[2] = 32'd0;
         m_reg[3] = 32'd0;
      end else if (m_on) begin
         aw_ok   = m_aw_h || bus.awvalid;
         w_ok    = m_w_h || bus.wvalid;
         a       = m_aw_h ? m_awaddr : bus.awaddr;
         d       = m_w_h ? m_wdata : bus.wdata;
         s       = m_w_h ? m_wstrb : bus.wstrb;
         commit  = aw_ok && w_ok && !m_b;
         nxt_irq = m_reg[2][0] & m_reg[0][2];
         if (bus.arvalid && !m_r) begin
            ri      = idx_of(bus.araddr);
            m_r     = 1'b1;
            m_rdata = m_read(ri);
            m_rresp = (ri < 0) ? 2'b10 : 2'b00;
         end else if (bus.rready) begin
            m_r = 1'b0;
         end
         if (commit) begin
            wi      = idx_of(a);
            m_b     = 1'b1;
            m_bresp = (wi < 0) ? 2'b10 : 2'b00;
            for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{s[i]}};
`ifndef VGA_AXIL_CSR_STRB_EN
            mask = 32'hFFFF_FFFF;
`endif
            if (wi == 2) begin
               if (d[0] && mask[0]) m_reg[2] = 32'd0;
            end else if (wi >= 0) begin
               m_reg[wi] = ((m_reg[wi] & ~mask) | (d & mask)) & rw_mask(wi);
            end
            m_aw_h = 1'b0;
            m_w_h  = 1'b0;
         end else begin
            if (bus.bready) m_b = 1'b0;
            if (bus.awvalid && !m_aw_h) begin m_aw_h = 1'b1; m_awaddr = bus.awaddr; end
            if (bus.wvalid && !m_w_h) begin m_w_h = 1'b1; m_wdata = bus.wdata; m_wstrb = bus.wstrb; end
         end
         if (frame_done_i) m_reg[2] = 32'd1;
         m_irq = nxt_irq;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (m_on) begin
         chk("awready", bus.awready, !m_aw_h);
         chk("wready", bus.wready, !m_w_h);
         chk("arready", bus.arready, !m_r);
         chk("bvalid", bus.bvalid, m_b);
         if (m_b) chk("bresp", bus.bresp, m_bresp);
         chk("rvalid", bus.rvalid, m_r);
         if (m_r) begin
            chk("rdata", bus.rdata, m_rdata);
            chk("rresp", bus.rresp, m_rresp);
         end
         chk("enable_o", enable_o, m_reg[0][0]);
         chk("test_pattern_o", test_pattern_o, m_reg[0][1]);
         chk("bg_color_o", {20'd0, bg_color_o}, m_reg[1]);
         chk("irq_o", irq_o, m_irq);
      end
   end

   // ---------------- bus helpers ----------------
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      bit got_b = 1'b0;
      resp = 2'b11;
      bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      for (int i = 0; i < 40 && !got_b; i++) begin
         bit aw_hs, w_hs;
         aw_hs = bus.awvalid && bus.awready;
         w_hs  = bus.wvalid && bus.wready;
         if (bus.bvalid && bus.bready) begin got_b = 1'b1; resp = bus.bresp; end
         @(negedge clk);
         if (aw_hs) bus.awvalid = 1'b0;
         if (w_hs) bus.wvalid = 1'b0;
      end
      if (!got_b) begin
         bus.awvalid = 1'b0; bus.wvalid = 1'b0;
         timeout("write_b");
      end
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      bit got = 1'b0;
      data = 32'hX; resp = 2'b11;
      bus.araddr = addr; bus.arvalid = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         bit ar_hs;
         ar_hs = bus.arvalid && bus.arready;
         if (bus.rvalid && bus.rready) begin got = 1'b1; data = bus.rdata; resp = bus.rresp; end
         @(negedge clk);
         if (ar_hs) bus.arvalid = 1'b0;
      end
      if (!got) begin
         bus.arvalid = 1'b0;
         timeout("read_r");
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] b;
      case ($urandom_range(0, 6))
         0:       b = 32'h0;
         1:       b = 32'h4;
         2:       b = 32'h8;
         3:       b = 32'hC;
         4:       b = 32'h10;
         5:       b = 32'h14;
         default: b = 32'h100;
      endcase
      return b | 32'($urandom_range(0, 3));
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] rd;
      logic [1:0]  rs, bs;
      bit          p_aw, p_w, p_ar;

      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = 4'hF; bus.wvalid = 1'b0;
      bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_awready", bus.awready, 32'd1);
      chk("rst_wready", bus.wready, 32'd1);
      chk("rst_arready", bus.arready, 32'd1);
      chk("rst_bvalid", bus.bvalid, 32'd0);
      chk("rst_rvalid", bus.rvalid, 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("rst_rresp", bus.rresp, 32'd0);
      chk("rst_bg", {20'd0, bg_color_o}, 32'h5A5);
      chk("rst_enable", enable_o, 32'd0);
      chk("rst_irq", irq_o, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // BG_COLOR write/readback
      axi_write(32'h4, 32'h0000_0ABC, 4'hF, bs);
      chk("bg_wr_resp", bs, 32'd0);
      chk("bg_out", {20'd0, bg_color_o}, 32'hABC);
      axi_read(32'h4, rd, rs);
      chk("bg_rd", rd, 32'h0000_0ABC);
      chk("bg_rd_resp", rs, 32'd0);

      // AW three cycles ahead of W
      bus.awaddr = 32'hC; bus.awvalid = 1'b1;
      @(negedge clk);
      bus.awvalid = 1'b0;
      chk("early_aw_awready", bus.awready, 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("early_aw_no_b", bus.bvalid, 32'd0);
      end
      bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      @(negedge clk);
      bus.wvalid = 1'b0;
      chk("late_w_bvalid", bus.bvalid, 32'd1);
      chk("late_w_bresp", bus.bresp, 32'd0);
      chk("late_w_awready", bus.awready, 32'd1);
      @(negedge clk);
      chk("late_w_single_b", bus.bvalid, 32'd0);
      axi_read(32'hC, rd, rs);
      chk("late_w_rd", rd, 32'h1234_5678);

      // undecoded addresses
      axi_read(32'h10, rd, rs);
      chk("bad_rd_resp", rs, 32'd2);
      chk("bad_rd_data", rd, 32'd0);
      axi_write(32'h14, 32'hDEAD_BEEF, 4'hF, bs);
      chk("bad_wr_resp", bs, 32'd2);
      axi_read(32'h4, rd, rs);
      chk("bad_wr_no_alias", rd, 32'h0000_0ABC);
      axi_read(32'hC, rd, rs);
      chk("bad_wr_scratch", rd, 32'h1234_5678);

      // CTRL read-zero bits
      axi_write(32'h0, 32'hFFFF_FFFF, 4'hF, bs);
      axi_read(32'h0, rd, rs);
      chk("ctrl_rd", rd, 32'h7);
      chk("ctrl_enable", enable_o, 32'd1);
      chk("ctrl_tp", test_pattern_o, 32'd1);

      // frame-done / IRQ / W1C
      frame_cnt_i = 16'h1234;
      axi_write(32'h0, 32'h4, 4'hF, bs);
      frame_done_i = 1'b1;
      @(negedge clk);
      frame_done_i = 1'b0;
      chk("irq_lag", irq_o, 32'd0);
      @(negedge clk);
      chk("irq_rise", irq_o, 32'd1);
      bus.awaddr = 32'h8; bus.wdata = 32'h1; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; frame_done_i = 1'b1;
      @(negedge clk);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; frame_done_i = 1'b0;
      @(negedge clk);
      axi_read(32'h8, rd, rs);
      chk("set_wins_clear", rd, 32'h1234_0001);
      chk("irq_held", irq_o, 32'd1);
      axi_write(32'h8, 32'h1, 4'hF, bs);
      axi_read(32'h8, rd, rs);
      chk("w1c_clear", rd, 32'h1234_0000);
      chk("irq_fall", irq_o, 32'd0);

      // B backpressure: second pair waits in the holds
      bus.bready = 1'b0;
      bus.awaddr = 32'hC; bus.wdata = 32'h1111_1111; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      @(negedge clk);
      bus.wdata = 32'h2222_2222;
      chk("bp_first_b", bus.bvalid, 32'd1);
      @(negedge clk);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      chk("bp_aw_held", bus.awready, 32'd0);
      chk("bp_w_held", bus.wready, 32'd0);
      repeat (3) @(negedge clk);
      chk("bp_b_stable", bus.bvalid, 32'd1);
      bus.bready = 1'b1;
      @(negedge clk);
      chk("bp_b_taken", bus.bvalid, 32'd0);
      chk("bp_still_held", bus.awready, 32'd0);
      @(negedge clk);
      chk("bp_second_b", bus.bvalid, 32'd1);
      chk("bp_hold_free", bus.awready, 32'd1);
      @(negedge clk);
      axi_read(32'hC, rd, rs);
      chk("bp_rd", rd, 32'h2222_2222);

      // byte strobes
      axi_write(32'hC, 32'hFFFF_FFFF, 4'hF, bs);
      axi_write(32'hC, 32'h0000_0000, 4'b0010, bs);
      axi_read(32'hC, rd, rs);
`ifdef VGA_AXIL_CSR_STRB_EN
      chk("strb_byte1", rd, 32'hFFFF_00FF);
`else
      chk("strb_ignored", rd, 32'h0000_0000);
`endif
      axi_write(32'hC, 32'hA5A5_A5A5, 4'b0000, bs);
      chk("strb0_resp", bs, 32'd0);
      axi_read(32'hC, rd, rs);
`ifdef VGA_AXIL_CSR_STRB_EN
      chk("strb0_nochange", rd, 32'hFFFF_00FF);
`else
      chk("strb0_fullword", rd, 32'hA5A5_A5A5);
`endif

      // randomized traffic, occasional mid-transaction reset
      p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (p_aw || !bus.awvalid || rst) begin
            bus.awvalid = ($urandom_range(0, 2) == 0);
            bus.awaddr  = rand_addr();
         end
         if (p_w || !bus.wvalid || rst) begin
            bus.wvalid = ($urandom_range(0, 2) == 0);
            bus.wdata  = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom;
            bus.wstrb  = 4'($urandom);
         end
         if (p_ar || !bus.arvalid || rst) begin
            bus.arvalid = ($urandom_range(0, 2) == 0);
            bus.araddr  = rand_addr();
         end
         bus.bready   = ($urandom_range(0, 3) != 0);
         bus.rready   = ($urandom_range(0, 3) != 0);
         frame_done_i = ($urandom_range(0, 7) == 0);
         frame_cnt_i  = 16'($urandom);
         rst          = ($urandom_range(0, 399) == 0);
         p_aw = bus.awvalid && bus.awready;
         p_w  = bus.wvalid && bus.wready;
         p_ar = bus.arvalid && bus.arready;
         @(negedge clk);
      end

      rst = 1'b0;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      bus.bready = 1'b1; bus.rready = 1'b1; frame_done_i = 1'b0;
      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
